// File: rtl/memory_access_if.sv
// Load/store stage signal bundle: execute request, processor memory bus and
// register write port toward write_back.
interface memory_access_if #(
  parameter int IDX_W = 6
);
  // execute -> memory_access request
  logic             in_valid;
  logic             in_ready;
  logic             in_load;
  logic             in_byte;
  logic             in_pre;
  logic             in_up;
  logic             in_wback;
  logic [31:0]      in_base;
  logic [31:0]      in_offset;
  logic [31:0]      in_sdata;
  logic [IDX_W-1:0] in_rd;
  logic [IDX_W-1:0] in_rn;
  // processor memory bus
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             abort;
  logic             write;
  logic             size;
  logic [1:0]       trans;
  // register write toward write_back
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic [31:0]      wb_data;
  logic             abort_o;

  // master: the load/store stage (bus master, request consumer)
  modport master (
    input  in_valid, in_load, in_byte, in_pre, in_up, in_wback,
    input  in_base, in_offset, in_sdata, in_rd, in_rn,
    input  rdata, abort,
    output in_ready, addr, wdata, write, size, trans,
    output wb_valid, wb_idx, wb_data, abort_o
  );

  // slave: the environment (execute stage, memory, write_back)
  modport slave (
    output in_valid, in_load, in_byte, in_pre, in_up, in_wback,
    output in_base, in_offset, in_sdata, in_rd, in_rn,
    output rdata, abort,
    input  in_ready, addr, wdata, write, size, trans,
    input  wb_valid, wb_idx, wb_data, abort_o
  );
endinterface

// File: rtl/memory_access.sv
// Load/store stage: runs one LDR/STR(B) per accepted request on the memory bus
// and emits load data and base writeback as single-cycle register writes.
module memory_access #(
  parameter int IDX_W = 6
) (
  input  logic            clk,
  input  logic            n_reset,
  memory_access_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_BASE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // request captured at accept
  logic             r_load;
  logic             r_byte;
  logic             r_wback;      // base writeback needed (explicit wback or post-index)
  logic [31:0]      r_upd;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [IDX_W-1:0] r_rd;
  logic [IDX_W-1:0] r_rn;

  // registered results
  logic             r_wb_valid;
  logic [IDX_W-1:0] r_wb_idx;
  logic [31:0]      r_wb_data;
  logic             r_abort_o;

  logic [31:0]      w_upd;
  logic [31:0]      w_sdata_rep;
  logic [7:0]       w_lane;
  logic [31:0]      w_load_data;
  logic             w_in_ready;
  logic [1:0]       w_trans;
  logic             w_write;
  logic             w_size;

  // Updated base address, wraps modulo 2^32
  always_comb begin
    w_upd = bus.in_up ? (bus.in_base + bus.in_offset) : (bus.in_base - bus.in_offset);
  end

  // Byte stores put the low store byte on every lane so any lane select works
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_sdata_rep[8*gi +: 8] = bus.in_sdata[7:0];
    end
  endgenerate

  // Little-endian byte lane pick and zero-extension for byte loads
  always_comb begin
    w_lane = bus.rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_lane = bus.rdata[7:0];
      2'd1: w_lane = bus.rdata[15:8];
      2'd2: w_lane = bus.rdata[23:16];
      2'd3: w_lane = bus.rdata[31:24];
      default: w_lane = bus.rdata[7:0];
    endcase
    w_load_data = r_byte ? {24'h000000, w_lane} : bus.rdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and bus control decoded from state
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_trans      = 2'b00;
    w_write      = 1'b0;
    w_size       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        w_trans      = 2'b10;
        w_write      = ~r_load;
        w_size       = ~r_byte;
        w_state_next = S_DATA;
      end
      S_DATA: begin
        if (bus.abort)              w_state_next = S_IDLE;
        else if (r_load && r_wback) w_state_next = S_BASE;
        else                        w_state_next = S_IDLE;
      end
      S_BASE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture and register-write generation (one write per cycle at most)
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_load     <= 1'b0;
      r_byte     <= 1'b0;
      r_wback    <= 1'b0;
      r_upd      <= 32'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rd       <= '0;
      r_rn       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_idx   <= '0;
      r_wb_data  <= 32'h0;
      r_abort_o  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_abort_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_load  <= bus.in_load;
            r_byte  <= bus.in_byte;
            r_wback <= bus.in_wback | ~bus.in_pre;
            r_upd   <= w_upd;
            r_addr  <= bus.in_pre ? w_upd : bus.in_base;
            r_wdata <= bus.in_byte ? w_sdata_rep : bus.in_sdata;
            r_rd    <= bus.in_rd;
            r_rn    <= bus.in_rn;
          end
        end
        S_DATA: begin
          if (bus.abort) begin
            r_abort_o <= 1'b1;
          end else if (r_load) begin
            r_wb_valid <= 1'b1;
            r_wb_idx   <= r_rd;
            r_wb_data  <= w_load_data;
          end else if (r_wback) begin
            r_wb_valid <= 1'b1;
            r_wb_idx   <= r_rn;
            r_wb_data  <= r_upd;
          end
        end
        S_BASE: begin
          r_wb_valid <= 1'b1;
          r_wb_idx   <= r_rn;
          r_wb_data  <= r_upd;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.trans    = w_trans;
  assign bus.write    = w_write;
  assign bus.size     = w_size;
  assign bus.addr     = r_addr;
  assign bus.wdata    = r_wdata;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_idx   = r_wb_idx;
  assign bus.wb_data  = r_wb_data;
  assign bus.abort_o  = r_abort_o;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: vector table of accesses against a small memory
// model, with bus and register-write scoreboards, plus reset/busy sequences.
module tb_memory_access;

  logic clk;
  logic n_reset;

  memory_access_if #(.IDX_W(6)) bus_if ();

  memory_access #(.IDX_W(6)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        load;
    logic        byte_acc;
    logic        pre;
    logic        up;
    logic        wback;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] sdata;
    logic [31:0] mem_word;
    logic [5:0]  rd;
    logic [5:0]  rn;
    logic        abort_inj;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int          n_wb;
    logic [5:0]  idx0;
    logic [31:0] d0;
    logic [5:0]  idx1;
    logic [31:0] d1;
    int          exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        size;
  } bus_exp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    int          cyc;
  } wb_exp_t;

  logic [31:0] mem [0:255];
  bus_exp_t    busq[$];
  wb_exp_t     wbq[$];
  int          abortq[$];
  int          n_checks;
  int          n_fail;
  int          cycle;
  logic        abort_inj;
  logic        abort_hold;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock: sample at negedge, check bus and write events, serve memory
  task automatic tick();
    bus_exp_t   be;
    wb_exp_t    we;
    int         ac;
    logic [7:0] idx;
    @(negedge clk);
    cycle++;
    if (bus_if.trans === 2'b10) begin
      if (busq.size() == 0) begin
        check32("bus_unexpected_trans", {30'h0, bus_if.trans}, 32'h0);
      end else begin
        be = busq.pop_front();
        check32("bus_addr", bus_if.addr, be.addr);
        check32("bus_write", {31'h0, bus_if.write}, {31'h0, be.write});
        check32("bus_size", {31'h0, bus_if.size}, {31'h0, be.size});
        if (be.write) check32("bus_wdata", bus_if.wdata, be.wdata);
      end
      idx = bus_if.addr[9:2];
      if (bus_if.write === 1'b1) begin
        if (bus_if.size === 1'b1) mem[idx] = bus_if.wdata;
        else mem[idx][8*bus_if.addr[1:0] +: 8] = bus_if.wdata[8*bus_if.addr[1:0] +: 8];
      end
      bus_if.rdata = mem[idx];
      bus_if.abort = abort_inj;
      abort_hold   = 1'b1;
    end else begin
      if (!abort_hold) bus_if.abort = 1'b0;
      abort_hold = 1'b0;
    end
    if (bus_if.wb_valid === 1'b1) begin
      if (wbq.size() == 0) begin
        check32("wb_unexpected", {26'h0, bus_if.wb_idx}, 32'hFFFF_FFFF);
      end else begin
        we = wbq.pop_front();
        check32("wb_idx", {26'h0, bus_if.wb_idx}, {26'h0, we.idx});
        check32("wb_data", bus_if.wb_data, we.data);
        check32("wb_cycle", cycle, we.cyc);
      end
    end
    if (bus_if.abort_o === 1'b1) begin
      if (abortq.size() == 0) begin
        check32("abort_unexpected", 32'h1, 32'h0);
      end else begin
        ac = abortq.pop_front();
        check32("abort_cycle", cycle, ac);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_in_ready"}, {31'h0, bus_if.in_ready}, 32'h1);
    check32({tag, "_addr"}, bus_if.addr, 32'h0);
    check32({tag, "_wdata"}, bus_if.wdata, 32'h0);
    check32({tag, "_wb_data"}, bus_if.wb_data, 32'h0);
    check32({tag, "_wb_idx"}, {26'h0, bus_if.wb_idx}, 32'h0);
    check32({tag, "_write"}, {31'h0, bus_if.write}, 32'h0);
    check32({tag, "_size"}, {31'h0, bus_if.size}, 32'h0);
    check32({tag, "_wb_valid"}, {31'h0, bus_if.wb_valid}, 32'h0);
    check32({tag, "_abort_o"}, {31'h0, bus_if.abort_o}, 32'h0);
    check32({tag, "_trans"}, {30'h0, bus_if.trans}, 32'h0);
  endtask

  task automatic drive_req(input vec_t v);
    bus_if.in_load   = v.load;
    bus_if.in_byte   = v.byte_acc;
    bus_if.in_pre    = v.pre;
    bus_if.in_up     = v.up;
    bus_if.in_wback  = v.wback;
    bus_if.in_base   = v.base;
    bus_if.in_offset = v.offset;
    bus_if.in_sdata  = v.sdata;
    bus_if.in_rd     = v.rd;
    bus_if.in_rn     = v.rn;
    bus_if.in_valid  = 1'b1;
  endtask

  task automatic check_queues_empty(input string tag);
    check32({tag, "_bus_left"}, busq.size(), 0);
    check32({tag, "_wb_left"}, wbq.size(), 0);
    check32({tag, "_abort_left"}, abortq.size(), 0);
  endtask

  vec_t vecs [11];

  initial begin
    vec_t v;
    int   c;
    int   n;

    // load byte pre up wb | base offset sdata mem | rd rn abort | addr wdata | nwb idx0 d0 idx1 d1 | ready
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 6'd5, 6'd1, 1'b0,
                 32'h104, 32'h0, 1, 6'd5, 32'hDEADBEEF, 6'd0, 32'h0, 3};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h3, 32'h0, 32'h11223344, 6'd7, 6'd0, 1'b0,
                 32'h203, 32'h0, 1, 6'd7, 32'h00000011, 6'd0, 32'h0, 3};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h8, 32'hCAFEF00D, 32'h0, 6'd9, 6'd2, 1'b0,
                 32'h40, 32'hCAFEF00D, 1, 6'd2, 32'h38, 6'd0, 32'h0, 3};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h4, 32'h0, 32'h55, 6'd3, 6'd3, 1'b0,
                 32'h14, 32'h0, 2, 6'd3, 32'h55, 6'd3, 32'h14, 4};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h10, 32'h0, 32'h12345678, 6'd4, 6'd6, 1'b1,
                 32'h310, 32'h0, 0, 6'd0, 32'h0, 6'd0, 32'h0, 3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1, 32'h123456A5, 32'h0, 6'd0, 6'd8, 1'b0,
                 32'h81, 32'hA5A5A5A5, 1, 6'd8, 32'h81, 6'd0, 32'h0, 3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h20, 32'h0BADC0DE, 32'h0, 6'd0, 6'd9, 1'b0,
                 32'h4E0, 32'h0BADC0DE, 0, 6'd0, 32'h0, 6'd0, 32'h0, 3};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h76543210, 6'd10, 6'd11, 1'b0,
                 32'hFFFFFFFC, 32'h0, 2, 6'd10, 32'h76543210, 6'd11, 32'h4, 4};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h208, 32'h0, 32'h0, 32'hAABBCC99, 6'd12, 6'd0, 1'b0,
                 32'h208, 32'h0, 1, 6'd12, 32'h00000099, 6'd0, 32'h0, 3};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h4, 32'h1, 32'h0, 6'd0, 6'd5, 1'b1,
                 32'h24, 32'h1, 0, 6'd0, 32'h0, 6'd0, 32'h0, 3};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h20, 32'h0, 32'h0000ABCD, 6'd1, 6'd2, 1'b0,
                 32'hFFFFFFF0, 32'h0, 2, 6'd1, 32'h0000ABCD, 6'd2, 32'hFFFFFFF0, 4};

    n_checks   = 0;
    n_fail     = 0;
    cycle      = 0;
    abort_inj  = 1'b0;
    abort_hold = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    n_reset          = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_load   = 1'b0;
    bus_if.in_byte   = 1'b0;
    bus_if.in_pre    = 1'b0;
    bus_if.in_up     = 1'b0;
    bus_if.in_wback  = 1'b0;
    bus_if.in_base   = 32'h0;
    bus_if.in_offset = 32'h0;
    bus_if.in_sdata  = 32'h0;
    bus_if.in_rd     = 6'd0;
    bus_if.in_rn     = 6'd0;
    bus_if.rdata     = 32'h0;
    bus_if.abort     = 1'b0;

    // reset state
    tick();
    tick();
    check_reset_outputs("reset");
    n_reset = 1'b1;
    tick();

    // table-driven accesses, each issued as soon as the stage is ready again
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      mem[v.exp_addr[9:2]] = v.mem_word;
      abort_inj = v.abort_inj;
      busq.push_back('{v.exp_addr, v.exp_wdata, ~v.load, ~v.byte_acc});
      c = cycle;
      if (v.abort_inj) begin
        abortq.push_back(c + 3);
      end else begin
        if (v.n_wb >= 1) wbq.push_back('{v.idx0, v.d0, c + 3});
        if (v.n_wb >= 2) wbq.push_back('{v.idx1, v.d1, c + 4});
      end
      drive_req(v);
      tick();
      bus_if.in_valid = 1'b0;
      n = 0;
      while (bus_if.in_ready !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      check32($sformatf("v%0d_ready_cycle", i), cycle - c, v.exp_ready);
      check_queues_empty($sformatf("v%0d", i));
      $display("txn %0d: load=%0b byte=%0b pre=%0b up=%0b wback=%0b base=%h off=%h addr=%h abort=%0b",
               i, v.load, v.byte_acc, v.pre, v.up, v.wback, v.base, v.offset, v.exp_addr, v.abort_inj);
    end
    abort_inj = 1'b0;

    // in_valid held while busy must not start a second access
    v = vecs[6];
    busq.push_back('{v.exp_addr, v.exp_wdata, 1'b1, 1'b1});
    c = cycle;
    drive_req(v);
    tick();
    bus_if.in_load = 1'b1;
    bus_if.in_base = 32'h700;
    tick();
    check32("busy_in_ready", {31'h0, bus_if.in_ready}, 32'h0);
    bus_if.in_valid = 1'b0;
    tick();
    check32("busy_ready_cycle", cycle - c, 3);
    for (int k = 0; k < 4; k++) tick();
    check_queues_empty("busy");
    $display("txn busy: STR held in_valid during ADDR/DATA, single bus transfer expected");

    // reset asserted while in ADDR drops the access with no writes
    v = vecs[3];
    mem[v.exp_addr[9:2]] = v.mem_word;
    busq.push_back('{v.exp_addr, v.exp_wdata, 1'b0, 1'b1});
    drive_req(v);
    tick();
    bus_if.in_valid = 1'b0;
    check32("midreset_in_addr", {30'h0, bus_if.trans}, 32'h2);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check_reset_outputs("midreset");
    for (int k = 0; k < 5; k++) tick();
    check_queues_empty("midreset");
    $display("txn midreset: LDR wback reset during ADDR, no register writes expected");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
